// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with stall, redirect, trap vectoring and halt/resume control
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]      TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_target,
    input  logic                 trap,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [WIDTH-1:0]     out_pc,
    output logic [WIDTH-1:0]     out_pc_plus,
    output logic [WIDTH-1:0]     epc,
    output logic                 misalign,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    localparam logic [WIDTH-1:0] TRAP_PC    = WIDTH'(TRAP_VECTOR);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam int unsigned      ALIGN_BITS = $clog2(STEP);

    typedef enum logic {RUN, HALTED} state_t;

    state_t               state, state_next;
    logic [WIDTH-1:0]     pc_next, epc_next;
    logic                 misalign_next;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 target_misaligned;

    assign out_pc_plus       = out_pc + STEP_W;
    assign target_misaligned = |redirect_target[ALIGN_BITS-1:0];
    assign halted            = (state == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            out_pc      <= RESET_VECTOR;
            epc         <= '0;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            out_pc      <= pc_next;
            epc         <= epc_next;
            misalign    <= misalign_next;
            fetch_count <= count_next;
        end
    end

    // halt_req does not suppress the PC update of its own cycle; halt takes effect from the next edge
    always_comb begin
        state_next    = state;
        pc_next       = out_pc;
        epc_next      = epc;
        misalign_next = 1'b0;
        count_next    = fetch_count;
        case (state)
            RUN: begin
                if (trap) begin
                    pc_next  = TRAP_PC;
                    epc_next = out_pc;
                end else if (redirect_valid && !target_misaligned) begin
                    pc_next = redirect_target;
                end else if (redirect_valid) begin
                    pc_next       = TRAP_PC;
                    epc_next      = redirect_target;
                    misalign_next = 1'b1;
                end else if (!stall) begin
                    pc_next    = out_pc_plus;
                    count_next = fetch_count + CNT_WIDTH'(1);
                end
                if (halt_req) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit (default and 8-bit configurations)
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, trap, halt_req, resume;
    logic [31:0] redirect_target;
    logic [31:0] out_pc, out_pc_plus, epc, fetch_count;
    logic        misalign, halted;

    logic       rst8, stall8, redirect_valid8, trap8, halt_req8, resume8;
    logic [7:0] redirect_target8;
    logic [7:0] out_pc8, out_pc_plus8, epc8;
    logic [3:0] fetch_count8;
    logic       misalign8, halted8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .trap(trap), .halt_req(halt_req), .resume(resume),
        .out_pc(out_pc), .out_pc_plus(out_pc_plus), .epc(epc), .misalign(misalign),
        .halted(halted), .fetch_count(fetch_count)
    );

    pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hF8), .CNT_WIDTH(4)) dut8 (
        .clk(clk), .rst(rst8), .stall(stall8), .redirect_valid(redirect_valid8),
        .redirect_target(redirect_target8), .trap(trap8), .halt_req(halt_req8), .resume(resume8),
        .out_pc(out_pc8), .out_pc_plus(out_pc_plus8), .epc(epc8), .misalign(misalign8),
        .halted(halted8), .fetch_count(fetch_count8)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; redirect_valid = 0; redirect_target = '0;
        trap = 0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst8 = 1; stall8 = 0; redirect_valid8 = 0; redirect_target8 = '0;
        trap8 = 0; halt_req8 = 0; resume8 = 0;
        clear_inputs();
        rst = 1;
        #2;
        expect_eq("rst_pc", out_pc, 0);
        expect_eq("rst_epc", epc, 0);
        expect_eq("rst_misalign", misalign, 0);
        expect_eq("rst_count", fetch_count, 0);
        expect_eq("rst_halted", halted, 0);
        expect_eq("rst_pc_plus", out_pc_plus, 4);
        tick();
        rst = 0;

        // sequential run
        for (int i = 0; i < 5; i++) begin
            expect_eq("seq_pc", out_pc, 32'(4 * i));
            expect_eq("seq_pc_plus", out_pc_plus, 32'(4 * i + 4));
            tick();
        end
        expect_eq("seq_pc_end", out_pc, 20);
        expect_eq("seq_count", fetch_count, 5);

        // stall then redirect overriding stall
        do_reset();
        advance(2);
        expect_eq("stall_pre_pc", out_pc, 8);
        stall = 1;
        tick(); expect_eq("stall_pc1", out_pc, 8);
        tick(); expect_eq("stall_pc2", out_pc, 8);
        redirect_valid = 1; redirect_target = 32'h40;
        tick();
        expect_eq("redir_over_stall_pc", out_pc, 32'h40);
        expect_eq("stall_count", fetch_count, 2);
        clear_inputs();

        // trap beats redirect
        do_reset();
        advance(8);
        trap = 1; redirect_valid = 1; redirect_target = 32'h80;
        tick();
        expect_eq("trap_pc", out_pc, 32'h100);
        expect_eq("trap_epc", epc, 32'h20);
        expect_eq("trap_misalign", misalign, 0);
        expect_eq("trap_count", fetch_count, 8);
        clear_inputs();

        // misaligned redirects
        do_reset();
        advance(12);
        expect_eq("mis_pre_pc", out_pc, 32'h30);
        redirect_valid = 1; redirect_target = 32'h42;
        tick();
        expect_eq("mis_pc", out_pc, 32'h100);
        expect_eq("mis_epc", epc, 32'h42);
        expect_eq("mis_pulse", misalign, 1);
        clear_inputs();
        tick();
        expect_eq("mis_drop", misalign, 0);
        expect_eq("mis_after_pc", out_pc, 32'h104);
        expect_eq("mis_count", fetch_count, 13);
        redirect_valid = 1; redirect_target = 32'h106;
        tick();
        expect_eq("mis2_a", misalign, 1);
        expect_eq("mis2_a_epc", epc, 32'h106);
        redirect_target = 32'h43;
        tick();
        expect_eq("mis2_b", misalign, 1);
        expect_eq("mis2_b_epc", epc, 32'h43);
        expect_eq("mis2_b_pc", out_pc, 32'h100);
        clear_inputs();
        tick();
        expect_eq("mis2_drop", misalign, 0);
        expect_eq("mis2_pc", out_pc, 32'h104);

        // halt / resume
        do_reset();
        advance(4);
        expect_eq("halt_pre_pc", out_pc, 32'h10);
        halt_req = 1;
        tick();
        expect_eq("halt_halted", halted, 1);
        expect_eq("halt_pc", out_pc, 32'h14);
        halt_req = 0; trap = 1; redirect_valid = 1; redirect_target = 32'h82; stall = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_eq("halted_pc", out_pc, 32'h14);
            expect_eq("halted_flag", halted, 1);
            expect_eq("halted_misalign", misalign, 0);
        end
        expect_eq("halted_epc", epc, 0);
        expect_eq("halted_count", fetch_count, 5);
        clear_inputs();
        resume = 1; halt_req = 1;
        tick();
        expect_eq("resume_halted", halted, 0);
        expect_eq("resume_pc", out_pc, 32'h14);
        clear_inputs();
        tick();
        expect_eq("post_resume_pc", out_pc, 32'h18);
        resume = 1;
        tick();
        expect_eq("resume_in_run_pc", out_pc, 32'h1c);
        expect_eq("resume_in_run_halted", halted, 0);
        clear_inputs();
        halt_req = 1; trap = 1;
        tick();
        expect_eq("halt_trap_pc", out_pc, 32'h100);
        expect_eq("halt_trap_epc", epc, 32'h1c);
        expect_eq("halt_trap_halted", halted, 1);
        clear_inputs();

        // async reset during a misalign pulse
        resume = 1;
        tick();
        clear_inputs();
        redirect_valid = 1; redirect_target = 32'h21;
        tick();
        clear_inputs();
        expect_eq("async_pre_mis", misalign, 1);
        @(negedge clk); #1;
        rst = 1;
        #1;
        expect_eq("async_mis", misalign, 0);
        expect_eq("async_pc", out_pc, 0);
        expect_eq("async_epc", epc, 0);
        tick();
        rst = 0;

        // 8-bit configuration: wrap of PC and counter, truncated trap vector
        tick();
        rst8 = 0;
        expect_eq("w8_rst_pc", out_pc8, 8'hF8);
        expect_eq("w8_rst_plus", out_pc_plus8, 8'hFC);
        tick(); expect_eq("w8_pc1", out_pc8, 8'hFC);
        expect_eq("w8_plus_wrap", out_pc_plus8, 8'h00);
        tick(); expect_eq("w8_pc2", out_pc8, 8'h00);
        expect_eq("w8_count2", fetch_count8, 2);
        advance(14);
        expect_eq("w8_count_wrap", fetch_count8, 0);
        expect_eq("w8_pc16", out_pc8, 8'h38);
        trap8 = 1;
        tick();
        trap8 = 0;
        expect_eq("w8_trap_pc", out_pc8, 8'h00);
        expect_eq("w8_trap_epc", epc8, 8'h38);
        halt_req8 = 1;
        tick();
        halt_req8 = 0;
        expect_eq("w8_halted", halted8, 1);
        expect_eq("w8_halt_pc", out_pc8, 8'h04);
        expect_eq("w8_halt_count", fetch_count8, 1);
        @(negedge clk); #1;
        rst8 = 1;
        #1;
        expect_eq("w8_async_pc", out_pc8, 8'hF8);
        expect_eq("w8_async_halted", halted8, 0);
        expect_eq("w8_async_count", fetch_count8, 0);
        expect_eq("w8_async_epc", epc8, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
